// File: rtl/arm_cu_pkg.sv
// Shared state codes, mux-select constants, ALU op and data-type codes for the ARM control unit.
package arm_cu_pkg;

    typedef enum logic [4:0] {
        S0  = 5'd0,  S1  = 5'd1,  S2  = 5'd2,  S3  = 5'd3,  S4  = 5'd4,
        S5  = 5'd5,  S6  = 5'd6,  S10 = 5'd10, S11 = 5'd11, S20 = 5'd20,
        S21 = 5'd21, S22 = 5'd22, S23 = 5'd23, S24 = 5'd24, S25 = 5'd25
    } state_t;

    localparam logic [1:0] MA_RN    = 2'b00, MA_MDR  = 2'b01, MA_R15 = 2'b10, MA_RD     = 2'b11;
    localparam logic [1:0] MB_SHIFT = 2'b00, MB_IMM  = 2'b01, MB_FOUR = 2'b10, MB_SIMM24 = 2'b11;
    localparam logic [1:0] MC_RD    = 2'b00, MC_R15  = 2'b01, MC_R14 = 2'b10, MC_RN     = 2'b11;

    localparam logic [4:0] OP_ADD   = 5'b00100;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_PASSA = 5'b10000;

    localparam logic [1:0] DT_BYTE = 2'b00, DT_HALF = 2'b01, DT_WORD = 2'b10;

    typedef struct packed {
        logic       fr_ld;
        logic       rf_ld;
        logic       ir_ld;
        logic       mar_ld;
        logic       mdr_ld;
        logic       r_w;
        logic       mov;
        logic [1:0] ma;
        logic [1:0] mb;
        logic [1:0] mc;
        logic       md;
        logic       me;
        logic [4:0] op;
        logic [1:0] dt;
    } ctrl_t;

    // Mode 3 (IR[27:26]=00) flags an immediate offset with IR[22]; mode 2 flags a register offset with IR[25].
    function automatic logic [1:0] mb_offset(input logic [31:0] ir);
        if (ir[27:26] == 2'b00)
            return ir[22] ? MB_IMM : MB_SHIFT;
        else
            return ir[25] ? MB_SHIFT : MB_IMM;
    endfunction

endpackage

// File: rtl/arm_cu_decoder.sv
// Decode-state target selection: maps IR and the condition result to the state after S5.
import arm_cu_pkg::*;

module arm_cu_decoder (
    input  logic [31:0] ir,
    input  logic        cond,
    output state_t      next_state,
    output logic [1:0]  dt
);
    logic unused_ir;
    assign unused_ir = ^{ir[31:28], ir[23], ir[21:8], ir[6:5], ir[3:0]};

    always_comb begin
        next_state = S1;
        dt         = DT_WORD;
        if (!cond)
            next_state = S1;
        else if (ir[27:25] == 3'b101)
            next_state = ir[24] ? S10 : S11;
        else if (ir[27:25] == 3'b000 && ir[7] && ir[4]) begin
            next_state = S20;
            dt         = DT_HALF;
        end else if (ir[27:26] == 2'b00)
            next_state = S6;
        else if (ir[27:26] == 2'b01) begin
            next_state = S20;
            dt         = ir[22] ? DT_BYTE : DT_WORD;
        end
    end
endmodule

// File: rtl/arm_control_unit.sv
// Moore sequencer for the multicycle ARM datapath. Define CU_TRACE_EN to print a per-edge
// trace of state and outputs while debug=1.
import arm_cu_pkg::*;

module arm_control_unit (
    input  logic        clk,
    input  logic        clr,
    output logic        FR_ld,
    output logic        RF_ld,
    output logic        IR_ld,
    output logic        MAR_ld,
    output logic        MDR_ld,
    output logic        R_W,
    output logic        MOV,
    output logic [1:0]  MA,
    output logic [1:0]  MB,
    output logic [1:0]  MC,
    output logic        MD,
    output logic        ME,
    output logic [4:0]  OP,
    output logic [1:0]  DT,
    input  logic [31:0] IR,
    input  logic        MOC,
    input  logic        COND,
    input  logic        debug
);
    state_t     state;
    state_t     dec_next;
    logic [1:0] dec_dt;
    logic [1:0] dt_q;
    ctrl_t      c;

    arm_cu_decoder u_dec (
        .ir         (IR),
        .cond       (COND),
        .next_state (dec_next),
        .dt         (dec_dt)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S0;
            dt_q  <= DT_WORD;
        end else begin
            case (state)
                S0:  state <= S1;
                S1:  state <= S2;
                S2:  state <= S3;
                S3:  state <= MOC ? S4 : S3;
                S4:  state <= S5;
                S5: begin
                    state <= dec_next;
                    // Transfer size is captured here so it stays stable through the whole access.
                    if (dec_next == S20)
                        dt_q <= dec_dt;
                end
                S6:  state <= S1;
                S10: state <= S11;
                S11: state <= S1;
                S20: state <= S21;
                S21: state <= IR[20] ? S22 : S24;
                S22: state <= MOC ? S23 : S22;
                S23: state <= S1;
                S24: state <= S25;
                S25: state <= MOC ? S1 : S25;
                default: state <= S0;
            endcase
        end
    end

    always_comb begin
        c    = '0;
        c.op = OP_PASSA;
        c.dt = (state inside {S20, S21, S22, S23, S24, S25}) ? dt_q : DT_WORD;
        case (state)
            S1: begin
                c.me     = 1'b1;
                c.mar_ld = 1'b1;
            end
            S2: begin
                c.ma     = MA_R15;
                c.mb     = MB_FOUR;
                c.op     = OP_ADD;
                c.mc     = MC_R15;
                c.rf_ld  = 1'b1;
                c.mov    = 1'b1;
                c.r_w    = 1'b1;
                c.mdr_ld = 1'b1;
            end
            S3, S22: begin
                c.mov    = 1'b1;
                c.r_w    = 1'b1;
                c.mdr_ld = 1'b1;
            end
            S4: c.ir_ld = 1'b1;
            S6: begin
                c.ma    = MA_RN;
                c.mb    = IR[25] ? MB_IMM : MB_SHIFT;
                c.op    = {1'b0, IR[24:21]};
                c.mc    = MC_RD;
                // TST/TEQ/CMP/CMN only set flags.
                c.rf_ld = (IR[24:23] != 2'b10);
                c.fr_ld = IR[20];
            end
            S10: begin
                c.ma    = MA_R15;
                c.mc    = MC_R14;
                c.rf_ld = 1'b1;
            end
            S11: begin
                c.ma    = MA_R15;
                c.mb    = MB_SIMM24;
                c.op    = OP_ADD;
                c.mc    = MC_R15;
                c.rf_ld = 1'b1;
            end
            S20: begin
                c.ma     = MA_RN;
                c.mb     = mb_offset(IR);
                c.op     = IR[24] ? (IR[23] ? OP_ADD : OP_SUB) : OP_PASSA;
                c.mar_ld = 1'b1;
            end
            S21: begin
                c.ma    = MA_RN;
                c.mb    = mb_offset(IR);
                c.op    = IR[23] ? OP_ADD : OP_SUB;
                c.mc    = MC_RN;
                c.rf_ld = IR[21] | ~IR[24];
            end
            S23: begin
                c.ma    = MA_MDR;
                c.mc    = MC_RD;
                c.rf_ld = 1'b1;
            end
            S24: begin
                c.ma     = MA_RD;
                c.md     = 1'b1;
                c.mdr_ld = 1'b1;
            end
            S25: c.mov = 1'b1;
            default: ;
        endcase
    end

    assign FR_ld  = c.fr_ld;
    assign RF_ld  = c.rf_ld;
    assign IR_ld  = c.ir_ld;
    assign MAR_ld = c.mar_ld;
    assign MDR_ld = c.mdr_ld;
    assign R_W    = c.r_w;
    assign MOV    = c.mov;
    assign MA     = c.ma;
    assign MB     = c.mb;
    assign MC     = c.mc;
    assign MD     = c.md;
    assign ME     = c.me;
    assign OP     = c.op;
    assign DT     = c.dt;

`ifdef CU_TRACE_EN
    always @(posedge clk) begin
        if (debug)
            $display("cu state=%0d FR_ld=%b RF_ld=%b IR_ld=%b MAR_ld=%b MDR_ld=%b R_W=%b MOV=%b MA=%b MB=%b MC=%b MD=%b ME=%b OP=%b DT=%b",
                     state, FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld, R_W, MOV, MA, MB, MC, MD, ME, OP, DT);
    end
`else
    logic unused_debug;
    assign unused_debug = debug;
`endif
endmodule

// File: tb/tb_arm_control_unit.sv
// Directed-step bench for arm_control_unit: reset, branch-with-link, condition fail,
// memory wait, data processing and a byte store interrupted by clr.
module tb_arm_control_unit;
    logic        clk = 1'b0;
    logic        clr, MOC, COND, debug;
    logic [31:0] IR;
    logic        FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld, R_W, MOV, MD, ME;
    logic [1:0]  MA, MB, MC, DT;
    logic [4:0]  OP;

    int n_cmp = 0;
    int n_err = 0;

    arm_control_unit dut (
        .clk(clk), .clr(clr), .FR_ld(FR_ld), .RF_ld(RF_ld), .IR_ld(IR_ld),
        .MAR_ld(MAR_ld), .MDR_ld(MDR_ld), .R_W(R_W), .MOV(MOV), .MA(MA), .MB(MB),
        .MC(MC), .MD(MD), .ME(ME), .OP(OP), .DT(DT), .IR(IR), .MOC(MOC),
        .COND(COND), .debug(debug)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int exp);
        chk(tag, 32'(dut.state), 32'(exp));
    endtask

    initial begin
        clr = 1'b1; MOC = 1'b0; COND = 1'b0; debug = 1'b0; IR = 32'h0;
        step(); step();
        chk_state("rst_state", 0);
        chk("rst_enables", {FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld, MOV}, 6'b0);
        chk("rst_op", OP, 5'b10000);
        chk("rst_dt", DT, 2'b10);

        clr = 1'b0;
        step();
        chk_state("s1", 1);
        chk("s1_mar_me", {MAR_ld, ME}, 2'b11);

        // B with link, memory ready immediately
        IR = 32'h0B000000; COND = 1'b1; MOC = 1'b1;
        step();
        chk_state("s2", 2);
        chk("s2_ctrl", {RF_ld, MC, MA, MB, OP, MOV, R_W, MDR_ld}, {1'b1, 2'b01, 2'b10, 2'b10, 5'b00100, 3'b111});
        step();
        chk_state("s3", 3);
        step();
        chk("s4_ir_ld", IR_ld, 1'b1);
        step();
        chk_state("s5", 5);
        chk("s5_rf_ld", RF_ld, 1'b0);
        step();
        chk_state("bl_s10", 10);
        chk("s10_ctrl", {RF_ld, MC, MA, OP}, {1'b1, 2'b10, 2'b10, 5'b10000});
        step();
        chk_state("bl_s11", 11);
        chk("s11_ctrl", {RF_ld, MC, MB, OP}, {1'b1, 2'b01, 2'b11, 5'b00100});
        step();
        chk_state("bl_back_s1", 1);

        // Same branch with condition failed
        COND = 1'b0;
        step(); step(); step(); step();
        chk_state("nc_s5", 5);
        step();
        chk_state("nc_s1", 1);
        chk("nc_rf_ld", RF_ld, 1'b0);

        // Memory wait in S3
        MOC = 1'b0;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk_state("wait_s3", 3);
            chk("wait_mov_rw", {MOV, R_W}, 2'b11);
        end
        MOC = 1'b1;
        step();
        chk_state("wait_s4", 4);
        chk("wait_ir_ld", IR_ld, 1'b1);

        // ADDS r2, r1, r3
        IR = 32'hE0912003; COND = 1'b1;
        step(); step();
        chk_state("adds_s6", 6);
        chk("adds_ctrl", {OP, RF_ld, FR_ld, MC, MB}, {5'b00100, 1'b1, 1'b1, 2'b00, 2'b00});
        step();
        chk_state("adds_s1", 1);

        // CMP r1, r2: flags only
        IR = 32'hE1510002;
        step(); step(); step(); step(); step();
        chk_state("cmp_s6", 6);
        chk("cmp_ctrl", {OP, RF_ld, FR_ld}, {5'b01010, 1'b0, 1'b1});
        step();

        // STRB r2, [r1, #4]
        IR = 32'hE5C12004;
        step(); step(); step(); step(); step();
        chk_state("strb_s20", 20);
        chk("s20_ctrl", {MAR_ld, ME, MA, MB, OP, DT}, {1'b1, 1'b0, 2'b00, 2'b01, 5'b00100, 2'b00});
        step();
        chk_state("strb_s21", 21);
        chk("s21_rf_ld_dt", {RF_ld, DT}, {1'b0, 2'b00});
        step();
        chk_state("strb_s24", 24);
        chk("s24_ctrl", {MD, MDR_ld, MA, OP, DT}, {1'b1, 1'b1, 2'b11, 5'b10000, 2'b00});
        MOC = 1'b0;
        step();
        chk_state("strb_s25", 25);
        chk("s25_ctrl", {MOV, R_W, DT}, {1'b1, 1'b0, 2'b00});
        step();
        chk_state("strb_s25_hold", 25);
        clr = 1'b1;
        step();
        chk_state("clr_s0", 0);
        chk("clr_outputs", {MOV, MDR_ld, DT}, {1'b0, 1'b0, 2'b10});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/arm_control_unit.md
Name: arm_control_unit

Overview:
- Moore-style FSM sequencer for the multicycle ARM datapath.
- Drives register/flag load enables, memory handshake, mux selects, ALU opcode and data type from the current state and the latched IR.
- Supports fetch, decode, condition check, data processing, single load/store (word/byte, mode-3 halfword) and B/BL.
- Sits between the instruction register/condition tester and the datapath/memory.

Parameters:
- none. State codes are package constants.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high reset
- FR_ld  out  1  flag register load
- RF_ld  out  1  register file write
- IR_ld  out  1  IR load from MDR
- MAR_ld  out  1  MAR load
- MDR_ld  out  1  MDR load
- R_W  out  1  1=read, 0=write
- MOV  out  1  memory operation valid
- MA  out  2  ALU A select: 00 Rn, 01 MDR, 10 R15, 11 Rd
- MB  out  2  ALU B select: 00 shifter(Rm), 01 IR immediate/offset, 10 constant 4, 11 sign-extended imm24<<2
- MC  out  2  RF destination: 00 Rd, 01 R15, 10 R14, 11 Rn
- MD  out  1  MDR source: 0 memory, 1 ALU
- ME  out  1  MAR source: 0 ALU, 1 R15
- OP  out  5  ALU op: {0,IR[24:21]} ARM opcodes; 5'b10000 pass A; ADD=00100, SUB=00010
- DT  out  2  00 byte, 01 halfword, 10 word
- IR  in  32  current instruction
- MOC  in  1  memory operation complete
- COND  in  1  condition of IR[31:28] satisfied
- debug  in  1  trace enable

Behaviour:
- State register updates on the rising edge of clk.
- clr=1 at an edge forces S0, including mid-memory-wait.
- All outputs are combinational from state (plus IR fields). Default for every output is 0; OP defaults to 10000 and DT to 10.
- In S0 all enables and MOV are 0.
- S0 RESET -> S1.
- S1 FETCH: ME=1, MAR_ld=1. -> S2.
- S2 INC: MA=10, MB=10, OP=ADD, MC=01, RF_ld=1; MOV=1, R_W=1, MDR_ld=1. -> S3.
- S3 FWAIT: MOV=1, R_W=1, MDR_ld=1. Stays in S3 while MOC=0; -> S4 when MOC=1. There is no timeout.
- S4 IRLD: IR_ld=1. -> S5.
- S5 DECODE: no enables. Next state:
  - COND=0 -> S1.
  - IR[27:25]=101 -> S10 if IR[24]=1, else S11.
  - IR[27:25]=000 with IR[7]=IR[4]=1 -> S20, mode-3, DT=01.
  - IR[27:26]=00 -> S6.
  - IR[27:26]=01 -> S20, DT=IR[22]?00:10.
  - Anything else (including 100, 11x) -> S1, treated as a NOP.
- S6 DP: MA=00, MB=IR[25]?01:00, OP={0,IR[24:21]}, MC=00.
  - RF_ld=1 except opcodes 10xx (TST/TEQ/CMP/CMN).
  - FR_ld=IR[20].
  - -> S1.
- S10 LINK: MA=10, OP=10000, MC=10, RF_ld=1. -> S11.
- S11 BRANCH: MA=10, MB=11, OP=ADD, MC=01, RF_ld=1. -> S1.
- S20 ADDR: MA=00, MB per mode offset, OP = IR[23]?ADD:SUB, ME=0, MAR_ld=1.
  - If IR[24]=0 (post-index), OP=10000 instead.
  - -> S21.
- S21 WB: if W=1 or P=0, Rn is updated with Rn±offset (MC=11, RF_ld=1). -> S22 if L=1, else S24.
- S22 LWAIT: MOV=1, R_W=1, MDR_ld=1, MD=0; hold until MOC=1. -> S23.
- S23 LDRD: MA=01, OP=10000, MC=00, RF_ld=1. -> S1.
- S24 STDT: MA=11, OP=10000, MD=1, MDR_ld=1. -> S25.
- S25 SWAIT: MOV=1, R_W=0; hold until MOC=1. -> S1.
- DT holds its decoded value throughout S20-S25 and is 10 otherwise.

Optional Feature:
- Macro CU_TRACE_EN.
- When defined and debug=1: on every rising edge, $display the state number and all outputs.
- When undefined: debug is ignored. No simulation output, identical logic.

Decomposition:
- Package arm_cu_pkg holds:
  - state enum/localparams S0-S25
  - MA/MB/MC select constants
  - OP codes (ADD, SUB, PASSA)
  - DT codes
- One sub-module is natural: arm_cu_decoder, combinational, maps IR and COND to the next-state target out of S5.

Test Plan:
- clr=1 for 2 edges, then 0 -> state S0 while clr high; S1 at the next edge (MAR_ld=1, ME=1).
- IR=0x0B000000, COND=1, MOC=1 -> S1, S2, S3, S4, S5, S10 (RF_ld=1, MC=10), S11 (RF_ld=1, MC=01, MB=11, OP=00100), S1.
- Same IR with COND=0 -> S5 returns to S1 with no RF_ld.
- MOC=0 held 5 cycles in S3 -> stays in S3 with MOV=1, R_W=1. MOC=1 -> S4, IR_ld=1.
- IR=0xE0912003 (ADDS) -> S6: OP=00100, RF_ld=1, FR_ld=1, MC=00, MB=00.
- IR=0xE5C12004 (STRB pre-index) -> S20, S21, S24, S25: DT=00, MD=1, R_W=0. clr mid-S25 -> S0.
